// File: rtl/mmio_pkg.sv
// Shared types, defaults and the address decoder for the MMIO bus controller.
// The optional SHADOW_COMMIT_EN macro is consumed by mmio_creg_bank.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int STATUS_IDX  = 0;
    localparam int DEC_AW      = 32;
    localparam int MAX_REGIONS = 8;

    typedef struct packed {
        logic       hit_region;
        logic [2:0] region_idx;
        logic       hit_creg;
        logic [3:0] creg_idx;
    } dec_t;

    // Bases are ascending, so the owning region is the highest base not above addr.
    function automatic dec_t mmio_decode(
        input logic [DEC_AW-1:0]             addr,
        input logic [MAX_REGIONS*DEC_AW-1:0] bases,
        input int                            num_regions,
        input logic [DEC_AW-1:0]             creg_base,
        input int                            num_cregs
    );
        dec_t              d;
        logic [DEC_AW-1:0] off;
        d   = '0;
        off = addr - creg_base;
        if ((addr >= bases[DEC_AW-1:0]) && (addr < creg_base)) begin
            d.hit_region = 1'b1;
            for (int i = 1; i < MAX_REGIONS; i++) begin
                if ((i < num_regions) && (addr >= bases[i*DEC_AW +: DEC_AW])) begin
                    d.region_idx = 3'(i);
                end
            end
        end else if ((addr >= creg_base) && (off < DEC_AW'(num_cregs))) begin
            d.hit_creg = 1'b1;
            d.creg_idx = off[3:0];
        end else begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/mmio_bus_controller_creg.sv
// Control-register bank: read-only status reg 0, writable cregs 1..N-1.
// With SHADOW_COMMIT_EN, writes land in shadows committed on vbright falling edge.
module mmio_creg_bank
    import mmio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_CREGS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_we,
    input  logic [3:0]                        i_idx,
    input  logic [DATA_W-1:0]                 i_wdata,
    input  logic                              hbright,
    input  logic                              vbright,
    output logic [DATA_W-1:0]                 o_rdata,
    output logic [(NUM_CREGS-1)*DATA_W-1:0]   o_creg_out
);

    logic [1:0]        r_status;
    logic [DATA_W-1:0] r_live [1:NUM_CREGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= 2'b00;
        end else begin
            r_status <= {hbright, vbright};
        end
    end

`ifdef SHADOW_COMMIT_EN
    logic [DATA_W-1:0] r_shadow [1:NUM_CREGS-1];
    logic              r_vb_d;
    logic              r_commit;

    // A same-cycle write overrides the commit so the newest value goes live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vb_d   <= 1'b0;
            r_commit <= 1'b0;
            for (int k = 1; k < NUM_CREGS; k++) begin
                r_shadow[k] <= '0;
                r_live[k]   <= '0;
            end
        end else begin
            r_vb_d   <= vbright;
            r_commit <= r_vb_d & ~vbright;
            for (int k = 1; k < NUM_CREGS; k++) begin
                if (r_commit) begin
                    r_live[k] <= r_shadow[k];
                end
                if (i_we && (i_idx == 4'(k))) begin
                    r_shadow[k] <= i_wdata;
                    if (r_commit) begin
                        r_live[k] <= i_wdata;
                    end
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_idx == 4'(STATUS_IDX)) begin
            o_rdata = DATA_W'(r_status);
        end else begin
            for (int k = 1; k < NUM_CREGS; k++) begin
                o_rdata = (i_idx == 4'(k)) ? r_shadow[k] : o_rdata;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < NUM_CREGS; k++) begin
                r_live[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NUM_CREGS; k++) begin
                if (i_we && (i_idx == 4'(k))) begin
                    r_live[k] <= i_wdata;
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_idx == 4'(STATUS_IDX)) begin
            o_rdata = DATA_W'(r_status);
        end else begin
            for (int k = 1; k < NUM_CREGS; k++) begin
                o_rdata = (i_idx == 4'(k)) ? r_live[k] : o_rdata;
            end
        end
    end
`endif

    for (genvar g = 1; g < NUM_CREGS; g++) begin : g_out
        assign o_creg_out[(g-1)*DATA_W +: DATA_W] = r_live[g];
    end

endmodule

// File: rtl/mmio_bus_controller.sv
// Memory-map controller: decodes CPU requests to RAM regions or cregs, inserts
// per-region wait states, returns ack/rdata. Optional feature macro: SHADOW_COMMIT_EN.
module mmio_bus_controller
    import mmio_pkg::*;
#(
    parameter int                           ADDR_W      = ADDR_W_DEF,
    parameter int                           DATA_W      = DATA_W_DEF,
    parameter int                           NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h4400, 16'h2400, 16'h2000, 16'h0000},
    parameter logic [NUM_REGIONS*4-1:0]     REGION_WAIT = {4'd0, 4'd0, 4'd0, 4'd0},
    parameter logic [ADDR_W-1:0]            CREG_BASE   = 16'h4800,
    parameter int                           NUM_CREGS   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [DATA_W-1:0]                 wdata,
    output logic                              ack,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              err,
    output logic                              busy,
    output logic [NUM_REGIONS-1:0]            region_en,
    output logic                              region_we,
    output logic [ADDR_W-1:0]                 region_addr,
    output logic [DATA_W-1:0]                 region_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0]     region_rdata,
    input  logic                              hbright,
    input  logic                              vbright,
    output logic [(NUM_CREGS-1)*DATA_W-1:0]   creg_out
);

    state_e                        r_state;
    logic                          r_we;
    logic                          r_hit_region;
    logic                          r_hit_creg;
    logic [2:0]                    r_region_idx;
    logic [3:0]                    r_creg_idx;
    logic [3:0]                    r_wait_cnt;
    logic                          r_ack;
    logic                          r_err;
    logic                          r_busy;
    logic                          r_ram_resp;
    logic [DATA_W-1:0]             r_rdata;
    logic [NUM_REGIONS-1:0]        r_region_en;
    logic                          r_region_we;
    logic [ADDR_W-1:0]             r_region_addr;
    logic [DATA_W-1:0]             r_region_wdata;

    logic [MAX_REGIONS*DEC_AW-1:0] w_bases_ext;
    dec_t                          w_dec;
    logic [ADDR_W-1:0]             w_base_sel;
    logic [3:0]                    w_wait_sel;
    logic [DATA_W-1:0]             w_ram_rdata;
    logic [DATA_W-1:0]             w_creg_rdata;
    logic                          w_creg_we;

    for (genvar g = 0; g < MAX_REGIONS; g++) begin : g_base
        if (g < NUM_REGIONS) begin : g_used
            assign w_bases_ext[g*DEC_AW +: DEC_AW] = DEC_AW'(REGION_BASE[g*ADDR_W +: ADDR_W]);
        end else begin : g_unused
            assign w_bases_ext[g*DEC_AW +: DEC_AW] = {DEC_AW{1'b1}};
        end
    end

    assign w_dec = mmio_decode(DEC_AW'(addr), w_bases_ext, NUM_REGIONS,
                               DEC_AW'(CREG_BASE), NUM_CREGS);

    // Per-region base (incoming request), wait count and read data (latched target).
    always_comb begin
        w_base_sel  = '0;
        w_wait_sel  = 4'd0;
        w_ram_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_base_sel  = (w_dec.region_idx == 3'(i)) ? REGION_BASE[i*ADDR_W +: ADDR_W] : w_base_sel;
            w_wait_sel  = (r_region_idx == 3'(i)) ? REGION_WAIT[i*4 +: 4] : w_wait_sel;
            w_ram_rdata = (r_region_idx == 3'(i)) ? region_rdata[i*DATA_W +: DATA_W] : w_ram_rdata;
        end
    end

    assign w_creg_we = (r_state == ST_RESP) && r_hit_creg && r_we;

    mmio_creg_bank #(
        .DATA_W    (DATA_W),
        .NUM_CREGS (NUM_CREGS)
    ) u_creg_bank (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_creg_we),
        .i_idx      (r_creg_idx),
        .i_wdata    (r_region_wdata),
        .hbright    (hbright),
        .vbright    (vbright),
        .o_rdata    (w_creg_rdata),
        .o_creg_out (creg_out)
    );

    // Access sequencer: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_we           <= 1'b0;
            r_hit_region   <= 1'b0;
            r_hit_creg     <= 1'b0;
            r_region_idx   <= 3'd0;
            r_creg_idx     <= 4'd0;
            r_wait_cnt     <= 4'd0;
            r_ack          <= 1'b0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_ram_resp     <= 1'b0;
            r_rdata        <= '0;
            r_region_en    <= '0;
            r_region_we    <= 1'b0;
            r_region_addr  <= '0;
            r_region_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we           <= we;
                        r_hit_region   <= w_dec.hit_region;
                        r_region_idx   <= w_dec.region_idx;
                        r_hit_creg     <= w_dec.hit_creg;
                        r_creg_idx     <= w_dec.creg_idx;
                        r_region_wdata <= wdata;
                        r_busy         <= 1'b1;
                        r_state        <= ST_ACCESS;
                        if (w_dec.hit_region) begin
                            r_region_en   <= NUM_REGIONS'(1) << w_dec.region_idx;
                            r_region_we   <= we;
                            r_region_addr <= addr - w_base_sel;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_region_en <= '0;
                    r_region_we <= 1'b0;
                    if (r_hit_region && (w_wait_sel != 4'd0)) begin
                        r_wait_cnt <= w_wait_sel;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_ack      <= 1'b1;
                        r_err      <= ~r_hit_region & ~r_hit_creg;
                        r_ram_resp <= r_hit_region;
                        r_rdata    <= r_hit_creg ? w_creg_rdata : '0;
                        r_state    <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt <= 4'd1) begin
                        r_ack      <= 1'b1;
                        r_err      <= 1'b0;
                        r_ram_resp <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_ack      <= 1'b0;
                    r_err      <= 1'b0;
                    r_ram_resp <= 1'b0;
                    r_rdata    <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_ack       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_region_en <= '0;
                    r_region_we <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Sync RAM data only exists during RESP, so RAM reads bypass the rdata register.
    assign rdata        = r_ram_resp ? w_ram_rdata : r_rdata;
    assign ack          = r_ack;
    assign err          = r_err;
    assign busy         = r_busy;
    assign region_en    = r_region_en;
    assign region_we    = r_region_we;
    assign region_addr  = r_region_addr;
    assign region_wdata = r_region_wdata;

endmodule
